// File: rtl/viewport_ctrl_if.sv
// Display-control and cell-toggle bus between viewport_ctrl, the VGA scan-out stage
// and the cell-memory writer.
interface viewport_ctrl_if #(
    parameter int unsigned WIDTH = 11
);
    logic [15:0]        shift_x;
    logic [15:0]        shift_y;
    logic [3:0]         scroll;
    logic               setting_status;
    logic [2*WIDTH-1:0] setting_pos;
    logic               toggle_req;
    logic [2*WIDTH-1:0] toggle_pos;
    logic               toggle_ack;

    modport master (
        output shift_x, shift_y, scroll, setting_status, setting_pos,
        output toggle_req, toggle_pos,
        input  toggle_ack
    );

    modport slave (
        input  shift_x, shift_y, scroll, setting_status, setting_pos,
        input  toggle_req, toggle_pos,
        output toggle_ack
    );
endinterface

// File: rtl/viewport_ctrl.sv
// Viewport/cursor controller: button sync + debounce, VIEW/SET/CLAMP FSM, cell-toggle req/ack.
// Define VIEWPORT_AUTO_REPEAT_EN to build auto-repeat on the four direction buttons.
module viewport_ctrl #(
    parameter int unsigned WIDTH           = 11,
    parameter int unsigned HSIZE           = 800,
    parameter int unsigned VSIZE           = 600,
    parameter int unsigned P_PARAM_N       = 1600,
    parameter int unsigned P_PARAM_M       = 1200,
    parameter int unsigned MAX_SCROLL      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_zoom_in,
    input  logic            btn_zoom_out,
    input  logic            btn_mode,
    input  logic            btn_toggle,
    viewport_ctrl_if.master vp
);
    localparam int unsigned NBTN  = 8;
    localparam int unsigned NDIR  = 4;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned DBW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_RIGHT = 3;
    localparam int unsigned B_ZIN   = 4;
    localparam int unsigned B_ZOUT  = 5;
    localparam int unsigned B_MODE  = 6;
    localparam int unsigned B_TOG   = 7;

    localparam logic [15:0] N_C          = 16'(P_PARAM_N);
    localparam logic [15:0] M_C          = 16'(P_PARAM_M);
    localparam logic [3:0]  SCROLL_MAX_C = 4'(MAX_SCROLL);

    // A zero timing parameter would make the counters meaningless.
    if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_cfg_chk
        $error("viewport_ctrl: timing parameters must be non-zero");
    end

    typedef enum logic [1:0] {
        ST_VIEW       = 2'd0,
        ST_SET        = 2'd1,
        ST_CLAMP_VIEW = 2'd2,
        ST_CLAMP_SET  = 2'd3
    } state_t;

    // ---------------- button front end ----------------
    logic [NBTN-1:0] btn_raw_c;
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] deb_q, deb_d;
    logic [NBTN-1:0] press_q, press_d;
    logic [DBW-1:0]  db_cnt_q [NBTN];
    logic [DBW-1:0]  db_cnt_d [NBTN];

    assign btn_raw_c = {btn_toggle, btn_mode, btn_zoom_out, btn_zoom_in,
                        btn_right, btn_left, btn_down, btn_up};

    // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; press is the 0->1 flip.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_d[i] = '0;
                deb_d[i]    = sync2_q[i];
                press_d[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw_c;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // ---------------- direction auto-repeat ----------------
    logic [NDIR-1:0] rpt_c;

`ifdef VIEWPORT_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0]   rpt_cnt_q [NDIR];
    logic [RW-1:0]   rpt_cnt_d [NDIR];
    logic [NDIR-1:0] rpt_armed_q, rpt_armed_d;
    logic [NDIR-1:0] rpt_q, rpt_d;

    // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_RATE.
    always_comb begin
        rpt_armed_d = rpt_armed_q;
        rpt_d       = '0;
        for (int i = 0; i < NDIR; i++) begin
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (!deb_q[i]) begin
                rpt_cnt_d[i]   = '0;
                rpt_armed_d[i] = 1'b0;
            end else if (!rpt_armed_q[i] && rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                rpt_cnt_d[i]   = '0;
                rpt_armed_d[i] = 1'b1;
                rpt_d[i]       = 1'b1;
            end else if (rpt_armed_q[i] && rpt_cnt_q[i] == RW'(REPEAT_RATE - 1)) begin
                rpt_cnt_d[i] = '0;
                rpt_d[i]     = 1'b1;
            end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_armed_q <= '0;
            rpt_q       <= '0;
            for (int i = 0; i < NDIR; i++) rpt_cnt_q[i] <= '0;
        end else begin
            rpt_armed_q <= rpt_armed_d;
            rpt_q       <= rpt_d;
            for (int i = 0; i < NDIR; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
        end
    end

    assign rpt_c = rpt_q;
`else
    assign rpt_c = '0;
`endif

    // ---------------- event decode ----------------
    logic [NDIR-1:0] dir_ev_c;
    logic [1:0]      dx_c, dy_c;
    logic            ev_mode_c, ev_tog_c, ev_zin_c, ev_zout_c;

    assign dir_ev_c  = press_q[NDIR-1:0] | rpt_c;
    assign dx_c      = {dir_ev_c[B_LEFT], dir_ev_c[B_RIGHT]};
    assign dy_c      = {dir_ev_c[B_UP],   dir_ev_c[B_DOWN]};
    assign ev_mode_c = press_q[B_MODE];
    assign ev_tog_c  = press_q[B_TOG];
    assign ev_zin_c  = press_q[B_ZIN];
    assign ev_zout_c = press_q[B_ZOUT];

    // dir 2'b01 steps up, 2'b10 steps down, anything else (idle or cancelled) holds.
    function automatic logic [15:0] sat_step(input logic [15:0] v, input logic [1:0] dir,
                                             input logic [15:0] hi);
        logic [15:0] r;
        r = v;
        if (dir == 2'b01 && v < hi)         r = v + 16'd1;
        else if (dir == 2'b10 && v != 16'd0) r = v - 16'd1;
        return r;
    endfunction

    // ---------------- viewport FSM ----------------
    state_t          state_q, state_d;
    logic [15:0]     sx_q, sx_d, sy_q, sy_d;
    logic [15:0]     cx_q, cx_d, cy_q, cy_d;
    logic [3:0]      scroll_q, scroll_d;
    logic            status_q, status_d;
    logic [PW-1:0]   spos_q, spos_d;
    logic            req_q, req_d;
    logic [PW-1:0]   tpos_q, tpos_d;
    logic [15:0]     vis_w_c, vis_h_c, max_x_c, max_y_c;

    assign vis_w_c = 16'(HSIZE) >> scroll_q;
    assign vis_h_c = 16'(VSIZE) >> scroll_q;
    assign max_x_c = (vis_w_c >= N_C) ? 16'd0 : N_C - vis_w_c;
    assign max_y_c = (vis_h_c >= M_C) ? 16'd0 : M_C - vis_h_c;

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        scroll_d = scroll_q;
        req_d    = req_q;
        tpos_d   = tpos_q;

        if (req_q && vp.toggle_ack) req_d = 1'b0;

        unique case (state_q)
            ST_VIEW, ST_SET: begin
                if (ev_mode_c) begin
                    if (state_q == ST_VIEW) begin
                        state_d = ST_SET;
                        cx_d    = sx_q + (vis_w_c >> 1);
                        cy_d    = sy_q + (vis_h_c >> 1);
                    end else begin
                        state_d = ST_VIEW;
                    end
                end else if (ev_tog_c) begin
                    if (state_q == ST_SET && !req_q) begin
                        req_d  = 1'b1;
                        tpos_d = spos_q;
                    end
                end else if (ev_zin_c) begin
                    if (scroll_q < SCROLL_MAX_C) begin
                        scroll_d = scroll_q + 4'd1;
                        state_d  = (state_q == ST_SET) ? ST_CLAMP_SET : ST_CLAMP_VIEW;
                    end
                end else if (ev_zout_c) begin
                    if (scroll_q != 4'd0) begin
                        scroll_d = scroll_q - 4'd1;
                        state_d  = (state_q == ST_SET) ? ST_CLAMP_SET : ST_CLAMP_VIEW;
                    end
                end else if (state_q == ST_VIEW) begin
                    sx_d = sat_step(sx_q, dx_c, max_x_c);
                    sy_d = sat_step(sy_q, dy_c, max_y_c);
                end else begin
                    cx_d = sat_step(cx_q, dx_c, N_C - 16'd1);
                    cy_d = sat_step(cy_q, dy_c, M_C - 16'd1);
                    // Pull the window just far enough to keep the cursor on screen.
                    if (cx_d < sx_q)                       sx_d = cx_d;
                    else if (cx_d > sx_q + vis_w_c - 16'd1) sx_d = cx_d - vis_w_c + 16'd1;
                    if (cy_d < sy_q)                       sy_d = cy_d;
                    else if (cy_d > sy_q + vis_h_c - 16'd1) sy_d = cy_d - vis_h_c + 16'd1;
                end
            end
            ST_CLAMP_VIEW, ST_CLAMP_SET: begin
                if (sx_q > max_x_c) sx_d = max_x_c;
                if (sy_q > max_y_c) sy_d = max_y_c;
                state_d = (state_q == ST_CLAMP_SET) ? ST_SET : ST_VIEW;
            end
            default: state_d = ST_VIEW;
        endcase

        status_d = (state_d == ST_SET) || (state_d == ST_CLAMP_SET);
        // Multiply stage: linear cursor address trails cx/cy by one register.
        spos_d   = PW'(32'(cy_q) * 32'(P_PARAM_N) + 32'(cx_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_VIEW;
            sx_q     <= '0;
            sy_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            scroll_q <= '0;
            status_q <= 1'b0;
            spos_q   <= '0;
            req_q    <= 1'b0;
            tpos_q   <= '0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            scroll_q <= scroll_d;
            status_q <= status_d;
            spos_q   <= spos_d;
            req_q    <= req_d;
            tpos_q   <= tpos_d;
        end
    end

    assign vp.shift_x        = sx_q;
    assign vp.shift_y        = sy_q;
    assign vp.scroll         = scroll_q;
    assign vp.setting_status = status_q;
    assign vp.setting_pos    = spos_q;
    assign vp.toggle_req     = req_q;
    assign vp.toggle_pos     = tpos_q;

endmodule

// File: tb/tb_viewport_ctrl.sv
// Directed bench for viewport_ctrl: expected values queued per step, compared once the DUT settles.
module tb_viewport_ctrl;
    localparam int unsigned WIDTH = 11;
    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
    localparam int B_ZIN = 4, B_ZOUT = 5, B_MODE = 6, B_TOG = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn = '0;
    int         total = 0;
    int         bad = 0;
    logic       ok;

    viewport_ctrl_if #(.WIDTH(WIDTH)) vif ();

    viewport_ctrl #(
        .WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up       (btn[0]),
        .btn_down     (btn[1]),
        .btn_left     (btn[2]),
        .btn_right    (btn[3]),
        .btn_zoom_in  (btn[4]),
        .btn_zoom_out (btn[5]),
        .btn_mode     (btn[6]),
        .btn_toggle   (btn[7]),
        .vp           (vif)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {F_SX, F_SY, F_SCROLL, F_STATUS, F_SPOS, F_REQ, F_TPOS} field_t;
    typedef struct packed { field_t f; logic [31:0] v; } exp_t;
    exp_t sb_q[$];

    function automatic logic [31:0] obs_of(input field_t f);
        case (f)
            F_SX:     return 32'(vif.shift_x);
            F_SY:     return 32'(vif.shift_y);
            F_SCROLL: return 32'(vif.scroll);
            F_STATUS: return 32'(vif.setting_status);
            F_SPOS:   return 32'(vif.setting_pos);
            F_REQ:    return 32'(vif.toggle_req);
            F_TPOS:   return 32'(vif.toggle_pos);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string name_of(input field_t f);
        case (f)
            F_SX:     return "shift_x";
            F_SY:     return "shift_y";
            F_SCROLL: return "scroll";
            F_STATUS: return "setting_status";
            F_SPOS:   return "setting_pos";
            F_REQ:    return "toggle_req";
            F_TPOS:   return "toggle_pos";
            default:  return "unknown";
        endcase
    endfunction

    task automatic push(input field_t f, input logic [31:0] v);
        exp_t e;
        e.f = f;
        e.v = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input string step);
        exp_t        e;
        logic [31:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_of(e.f);
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s.%s observed=%0d expected=%0d", step, name_of(e.f), o, e.v);
            end
        end
    endtask

    task automatic timeout_check(input string step, input logic seen);
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL %s observed=timeout expected=event", step);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        cycles(hold);
        btn[b] = 1'b0;
        cycles(12);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        btn = '0;
        vif.toggle_ack = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic push_reset_vals;
        push(F_SX, 0); push(F_SY, 0); push(F_SCROLL, 0); push(F_STATUS, 0);
        push(F_SPOS, 0); push(F_REQ, 0); push(F_TPOS, 0);
    endtask

    initial begin
        vif.toggle_ack = 1'b0;
        @(negedge clk);
        push_reset_vals();
        check("in_reset");
        do_reset();
        push_reset_vals();
        check("after_reset");

        // Toggle in VIEW is ignored
        push(F_REQ, 0);
        press(B_TOG, 10);
        check("view_toggle");

        // Move and saturate at 0
        push(F_SX, 1);
        press(B_RIGHT, 10);
        check("right1");
        push(F_SX, 0);
        press(B_LEFT, 10);
        press(B_LEFT, 10);
        check("left_sat0");

        // Drive shift_x to its scroll-0 limit of 800
        push(F_SX, 800); push(F_SCROLL, 0);
`ifdef VIEWPORT_AUTO_REPEAT_EN
        press(B_RIGHT, 6700);
`else
        for (int k = 0; k < 805; k++) press(B_RIGHT, 10);
`endif
        check("right_to_800");

        push(F_SCROLL, 1); push(F_SX, 800);
        press(B_ZIN, 10);
        check("zin1");
        push(F_SCROLL, 4); push(F_SX, 800);
        for (int k = 0; k < 3; k++) press(B_ZIN, 10);
        check("zin4");
        push(F_SCROLL, 4);
        press(B_ZIN, 10);
        check("zin_sat");

        push(F_SCROLL, 1); push(F_SX, 800);
        for (int k = 0; k < 3; k++) press(B_ZOUT, 10);
        check("zout_to1");

        push(F_SX, 1200);
`ifdef VIEWPORT_AUTO_REPEAT_EN
        press(B_RIGHT, 3500);
`else
        for (int k = 0; k < 405; k++) press(B_RIGHT, 10);
`endif
        check("right_to_1200");

        // Zoom out: scroll new first, clamped shift one cycle later
        btn[B_ZOUT] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (vif.scroll != 4'd1) ok = 1'b1;
        end
        timeout_check("zout_wait", ok);
        push(F_SCROLL, 0); push(F_SX, 1200);
        check("clamp_n1");
        @(negedge clk);
        push(F_SX, 800);
        check("clamp_n2");
        btn[B_ZOUT] = 1'b0;
        cycles(12);
        push(F_SCROLL, 0); push(F_SX, 800);
        for (int k = 0; k < 3; k++) press(B_ZOUT, 10);
        check("zout_sat");

        // SET entry from reset; setting_pos trails status by one cycle
        do_reset();
        btn[B_MODE] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (vif.setting_status) ok = 1'b1;
        end
        timeout_check("mode_wait", ok);
        push(F_STATUS, 1); push(F_SPOS, 0);
        check("set_lag0");
        @(negedge clk);
        push(F_SPOS, 480400);
        check("set_lag1");
        btn[B_MODE] = 1'b0;
        cycles(12);

        // 2-cycle glitch on up is filtered
        push(F_SPOS, 480400);
        btn[B_UP] = 1'b1;
        cycles(2);
        btn[B_UP] = 1'b0;
        cycles(12);
        check("glitch_up");

        // Toggle handshake
        push(F_REQ, 1); push(F_TPOS, 480400);
        press(B_TOG, 10);
        check("toggle1");
        push(F_REQ, 1); push(F_TPOS, 480400); push(F_SPOS, 480401); push(F_SX, 0);
        press(B_TOG, 10);
        press(B_RIGHT, 10);
        check("toggle_pending");
        vif.toggle_ack = 1'b1;
        @(negedge clk);
        vif.toggle_ack = 1'b0;
        push(F_REQ, 0); push(F_TPOS, 480400);
        check("ack");
        push(F_REQ, 1); push(F_TPOS, 480401);
        press(B_TOG, 10);
        check("toggle2");

        // Async reset with a pending request, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        push_reset_vals();
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Mode and right in the same cycle: only the mode event is taken
        push(F_STATUS, 1); push(F_SX, 0); push(F_SPOS, 480400);
        btn[B_MODE] = 1'b1;
        btn[B_RIGHT] = 1'b1;
        cycles(10);
        btn = '0;
        cycles(12);
        check("mode_right");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
